// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin search helper for the FIFO write arbiters.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

   localparam int RR_MAX_REQ = 32;
   localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

   // First set bit of valid searching last+1 .. last, wrapping at n (need not be a power of two).
   // Scanning downwards lets the nearest candidate overwrite farther ones without an early exit.
   // Returns last when nothing is valid.
   function automatic int rr_next(input int n, input int last,
                                  input logic [RR_MAX_REQ-1:0] valid);
      int pick;
      int idx;
      pick = last;
      for (int k = RR_MAX_REQ; k >= 1; k--) begin
         idx = last + k;
         if (idx >= n) begin
            idx = idx - n;
         end
         if ((k <= n) && valid[idx[RR_IDX_W-1:0]]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after last, wrapping at NUM_REQ.
// Zero latency; no flow control of its own.
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  valid,
   input  logic [ID_WIDTH-1:0] last,
   output logic [ID_WIDTH-1:0] pick,
   output logic                any
);
   import fifo_arb_pkg::*;

   logic [RR_MAX_REQ-1:0] valid_ext;

   always_comb begin
      valid_ext              = '0;
      valid_ext[NUM_REQ-1:0] = valid;
      pick                   = ID_WIDTH'(rr_next(NUM_REQ, int'(last), valid_ext));
      any                    = |valid;
   end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; grant 1 cycle after request, 1 bubble between grants.
// Bursts stall on fifo_full with the grant held; fifo_almost_full only blocks new grants.
module fifo_rr_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           fifo_wr_en,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
   input  logic                           fifo_full,
   input  logic                           fifo_almost_full,
   output logic [ID_WIDTH-1:0]            grant_id,
   output logic                           busy
);
   import fifo_arb_pkg::*;

   localparam int                  CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]    BEAT_LIMIT = CNT_W'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0] LAST_RST   = ID_WIDTH'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [ID_WIDTH-1:0] owner_q, owner_d;
   logic [ID_WIDTH-1:0] last_owner_q, last_owner_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

   logic [ID_WIDTH-1:0]   pick;
   logic                  pick_any;
   logic                  own_valid;
   logic                  own_last;
   logic [DATA_WIDTH-1:0] own_data;
   logic                  in_burst;
   logic                  accept;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_pick (
      .valid (req_valid),
      .last  (last_owner_q),
      .pick  (pick),
      .any   (pick_any)
   );

   // Compare-based owner mux so an unused tag code never indexes past the request vectors.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_WIDTH'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign in_burst = (state_q == ARB_BURST);
   assign accept   = in_burst && own_valid && !fifo_full;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = in_burst && (owner_q == ID_WIDTH'(i)) && !fifo_full;
      end
   end

   assign fifo_wr_en = accept;
   assign fifo_din   = {owner_q, own_data};
   assign grant_id   = owner_q;
   assign busy       = in_burst;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any && !fifo_almost_full) begin
               owner_d      = pick;
               last_owner_d = pick;
               beat_cnt_d   = '0;
               state_d      = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               // Last beat and burst limit together still make a single exit.
               if (own_last || (beat_cnt_q == BEAT_LIMIT)) begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_RST;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Bench for fifo_rr_write_arbiter: vector table, directed corner sequences, randomized run against a model.
module tb_fifo_rr_write_arbiter;

   localparam int MB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-requester instance
   logic         rst;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [127:0] req_data;
   logic         fifo_wr_en, fifo_full, fifo_almost_full, busy;
   logic [33:0]  fifo_din;
   logic [1:0]   grant_id;

   // 3-requester instance
   logic        rst3, wr3, full3, af3, busy3;
   logic [2:0]  v3, l3, r3;
   logic [95:0] d3;
   logic [33:0] din3;
   logic [1:0]  gid3;

   fifo_rr_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .fifo_almost_full(fifo_almost_full), .grant_id(grant_id), .busy(busy)
   );

   fifo_rr_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(MB)) dut3 (
      .clk(clk), .rst(rst3), .req_valid(v3), .req_data(d3), .req_last(l3),
      .req_ready(r3), .fifo_wr_en(wr3), .fifo_din(din3), .fifo_full(full3),
      .fifo_almost_full(af3), .grant_id(gid3), .busy(busy3)
   );

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic       f;
      logic       a;
      logic       b;
      logic [1:0] g;
      logic [3:0] r;
      logic       w;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic        m_busy;
   int          m_owner, m_last, m_beats;
   logic        e_wr;
   logic [3:0]  e_r;
   logic [33:0] e_din;
   logic [31:0] rd [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_last = '0;
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [63:0] pk(logic b, logic [1:0] g, logic [3:0] r, logic w, logic [33:0] d);
      return {22'd0, b, g, r, w, d};
   endfunction

   function automatic logic [33:0] cdin(int t);
      return {2'(t), 32'hC0DE_0000 + 32'(t)};
   endfunction

   function automatic vec_t mk(int v, int l, int f, int a, int b, int g, int r, int w);
      vec_t x;
      x.v = 4'(v); x.l = 4'(l); x.f = 1'(f); x.a = 1'(a);
      x.b = 1'(b); x.g = 2'(g); x.r = 4'(r); x.w = 1'(w);
      return x;
   endfunction

   function automatic int tb_pick(int last, logic [3:0] v, int n);
      for (int k = 1; k <= n; k++) begin
         if (v[(last + k) % n]) return (last + k) % n;
      end
      return last;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl [24];
      int   nwr;
      logic gok;

      rst3 = 1'b1; v3 = '0; l3 = '0; full3 = 1'b0; af3 = 1'b0;
      for (int i = 0; i < 3; i++) d3[i*32 +: 32] = 32'h3000_0000 + 32'(i);
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);

      //        v  l  f  a   busy gid ready wr
      tbl[0]  = mk(4, 0, 0, 0,  0, 0, 0, 0);   // req 2 burst of 3
      tbl[1]  = mk(4, 0, 0, 0,  1, 2, 4, 1);
      tbl[2]  = mk(4, 0, 0, 0,  1, 2, 4, 1);
      tbl[3]  = mk(4, 4, 0, 0,  1, 2, 4, 1);
      tbl[4]  = mk(0, 0, 0, 0,  0, 2, 0, 0);
      tbl[5]  = mk(1, 0, 0, 1,  0, 2, 0, 0);   // almost_full blocks grant
      tbl[6]  = mk(1, 0, 0, 1,  0, 2, 0, 0);
      tbl[7]  = mk(1, 0, 0, 0,  0, 2, 0, 0);
      tbl[8]  = mk(1, 1, 0, 0,  1, 0, 1, 1);
      tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0);
      tbl[10] = mk(2, 0, 0, 0,  0, 0, 0, 0);   // req 1, full for 5 cycles
      tbl[11] = mk(2, 0, 0, 0,  1, 1, 2, 1);
      for (int i = 12; i <= 16; i++) tbl[i] = mk(2, 0, 1, 0, 1, 1, 0, 0);
      tbl[17] = mk(2, 0, 0, 0,  1, 1, 2, 1);
      tbl[18] = mk(2, 2, 0, 0,  1, 1, 2, 1);
      tbl[19] = mk(0, 0, 0, 0,  0, 1, 0, 0);
      tbl[20] = mk(1, 0, 0, 0,  0, 1, 0, 0);   // owner drops valid mid-burst
      tbl[21] = mk(0, 0, 0, 0,  1, 0, 1, 0);
      tbl[22] = mk(1, 1, 0, 0,  1, 0, 1, 1);
      tbl[23] = mk(0, 0, 0, 0,  0, 0, 0, 0);

      do_reset();
      @(negedge clk);
      chk("reset", pk(busy, grant_id, req_ready, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));
      tick();

      for (int i = 0; i < 24; i++) begin
         req_valid = tbl[i].v; req_last = tbl[i].l;
         fifo_full = tbl[i].f; fifo_almost_full = tbl[i].a;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             pk(busy, grant_id, req_ready, fifo_wr_en, tbl[i].w ? fifo_din : 34'd0),
             pk(tbl[i].b, tbl[i].g, tbl[i].r, tbl[i].w, tbl[i].w ? cdin(int'(tbl[i].g)) : 34'd0));
         tick();
      end

      // reset during beat 2 of a burst from requester 3
      req_valid = 4'b1000; req_last = '0;
      @(negedge clk);
      chk("s5_idle", pk(busy, 2'd0, req_ready, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));
      tick();
      @(negedge clk);
      chk("s5_beat1", pk(busy, grant_id, req_ready, fifo_wr_en, fifo_din), pk(1'b1, 2'd3, 4'b1000, 1'b1, cdin(3)));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; req_valid = 4'b1001;
      @(negedge clk);
      chk("s5_after_rst", pk(busy, 2'd0, req_ready, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));
      tick();
      @(negedge clk);
      chk("s5_first_grant", pk(busy, grant_id, req_ready, fifo_wr_en, fifo_din), pk(1'b1, 2'd0, 4'b0001, 1'b1, cdin(0)));

      // all four requesters with endless bursts
      do_reset();
      req_valid = 4'hF; req_last = '0;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         chk($sformatf("s2_bubble%0d", g), pk(busy, 2'd0, 4'd0, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));
         tick();
         nwr = 0; gok = 1'b1;
         for (int b = 0; b < MB; b++) begin
            @(negedge clk);
            if (fifo_wr_en) nwr++;
            if (!busy || grant_id != 2'(g % 4)) gok = 1'b0;
            tick();
         end
         chk($sformatf("s2_beats%0d", g), 64'(nwr), 64'(MB));
         chk($sformatf("s2_owner%0d", g), {63'd0, gok}, 64'd1);
      end
      @(negedge clk);
      chk("s2_bubble_end", pk(busy, 2'd0, 4'd0, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));

      // last beat coincides with the MAX_BURST limit
      do_reset();
      req_valid = 4'b0001; req_last = '0;
      tick();
      nwr = 0;
      for (int b = 0; b < MB; b++) begin
         if (b == MB - 1) req_last = 4'b0001;
         @(negedge clk);
         if (fifo_wr_en) nwr++;
         tick();
      end
      req_valid = '0; req_last = '0;
      @(negedge clk);
      chk("lim_beats", 64'(nwr), 64'(MB));
      chk("lim_exit", pk(busy, 2'd0, req_ready, fifo_wr_en, 34'd0), pk(1'b0, 2'd0, 4'd0, 1'b0, 34'd0));
      tick();

      // three requesters, 0 and 2 valid with single-beat bursts
      rst3 = 1'b1;
      tick();
      tick();
      rst3 = 1'b0; v3 = 3'b101; l3 = 3'b111;
      nwr = 0;
      for (int c = 0; c < 40 && nwr < 6; c++) begin
         @(negedge clk);
         if (busy3) chk("s6_gid_range", 64'(gid3 <= 2'd2), 64'd1);
         if (wr3) begin
            chk($sformatf("s6_write%0d", nwr), {27'd0, r3, din3},
                {27'd0, (nwr % 2 == 0) ? 3'b001 : 3'b100, 2'((nwr % 2) * 2), 32'h3000_0000 + 32'((nwr % 2) * 2)});
            nwr++;
         end
         tick();
      end
      chk("s6_count", 64'(nwr), 64'd6);
      v3 = '0;

      // randomized run against the reference model
      do_reset();
      m_busy = 1'b0; m_owner = 0; m_last = 3; m_beats = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         req_valid = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            req_last[i] = ($urandom_range(0, 3) == 0);
            rd[i] = $urandom;
         end
         req_data = {rd[3], rd[2], rd[1], rd[0]};
         fifo_full = ($urandom_range(0, 7) == 0);
         fifo_almost_full = ($urandom_range(0, 3) == 0);

         e_wr  = m_busy && req_valid[m_owner] && !fifo_full;
         e_r   = (m_busy && !fifo_full) ? 4'(1 << m_owner) : 4'd0;
         e_din = {2'(m_owner), rd[m_owner]};
         @(negedge clk);
         chk($sformatf("rand%0d", c),
             pk(busy, grant_id, req_ready, fifo_wr_en, e_wr ? fifo_din : 34'd0),
             pk(m_busy, 2'(m_owner), e_r, e_wr, e_wr ? e_din : 34'd0));

         if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_last = 3; m_beats = 0;
         end else if (!m_busy) begin
            if (req_valid != 4'd0 && !fifo_almost_full) begin
               m_owner = tb_pick(m_last, req_valid, 4);
               m_last = m_owner;
               m_beats = 0;
               m_busy = 1'b1;
            end
         end else if (e_wr) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) m_busy = 1'b0;
         end
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
